// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Purpose  : Serialises instruction-fetch and MEM-stage traffic onto a
//            byte-wide RAM port; assembles little-endian load data.
// Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_fin,
    output logic [31:0] if_out,
    input  logic [1:0]  mem_op,
    input  logic [1:0]  mem_len,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    output logic        mem_fin,
    output logic [31:0] mem_out,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_a,
    output logic        ram_wr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] C_OP_LOAD  = 2'b01;
    localparam logic [1:0] C_OP_SAVE  = 2'b10;
    localparam logic [1:0] C_OWN_NONE = 2'd0;
    localparam logic [1:0] C_OWN_IF   = 2'd1;
    localparam logic [1:0] C_OWN_MEM  = 2'd2;

    state_t      r_state;
    logic [1:0]  r_owner;
    logic        r_store;
    logic [2:0]  r_n;
    logic [2:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [31:0] r_buf;
    logic        r_ram_wr;

    logic        w_mem_go;
    logic [2:0]  w_mem_n;
    logic [2:0]  w_next_cnt;
    logic [31:0] w_next_addr;
    logic [31:0] w_next_buf;
    logic [7:0]  w_store_byte;

    // A held store byte must not be written again while the pipeline is frozen
    assign ram_wr = r_ram_wr & rdy_in;

    // Request decode, next-byte address/data and load-byte merge
    always_comb begin
        w_mem_go    = (mem_op == C_OP_LOAD) || (mem_op == C_OP_SAVE);
        case (mem_len)
            2'b00:   w_mem_n = 3'd1;
            2'b01:   w_mem_n = 3'd2;
            default: w_mem_n = 3'd4;
        endcase
        w_next_cnt  = r_cnt + 3'd1;
        w_next_addr = r_addr + {29'd0, w_next_cnt};
        // ram_din carries the byte addressed one cycle earlier, i.e. byte r_cnt-1
        w_next_buf  = r_buf;
        for (int b = 0; b < 4; b++) begin
            if (r_cnt == 3'(b + 1)) begin
                w_next_buf[8*b +: 8] = ram_din;
            end
        end
        case (w_next_cnt[1:0])
            2'd1:    w_store_byte = r_data[15:8];
            2'd2:    w_store_byte = r_data[23:16];
            2'd3:    w_store_byte = r_data[31:24];
            default: w_store_byte = r_data[7:0];
        endcase
    end

    // Arbitration, byte sequencing and registered outputs
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state  <= ST_IDLE;
            r_owner  <= C_OWN_NONE;
            r_store  <= 1'b0;
            r_n      <= 3'd0;
            r_cnt    <= 3'd0;
            r_addr   <= 32'd0;
            r_data   <= 32'd0;
            r_buf    <= 32'd0;
            r_ram_wr <= 1'b0;
            if_fin   <= 1'b0;
            if_out   <= 32'd0;
            mem_fin  <= 1'b0;
            mem_out  <= 32'd0;
            ram_dout <= 8'd0;
            ram_a    <= 32'd0;
        end else if (rdy_in) begin
            case (r_state)
                ST_IDLE: begin
                    if_fin  <= 1'b0;
                    mem_fin <= 1'b0;
                    r_cnt   <= 3'd0;
                    r_buf   <= 32'd0;
                    if (w_mem_go) begin
                        r_owner  <= C_OWN_MEM;
                        r_store  <= (mem_op == C_OP_SAVE);
                        r_n      <= w_mem_n;
                        r_addr   <= mem_addr;
                        r_data   <= mem_data;
                        ram_a    <= mem_addr;
                        ram_dout <= mem_data[7:0];
                        r_ram_wr <= (mem_op == C_OP_SAVE);
                        r_state  <= ST_BUSY;
                    end else if (if_req) begin
                        r_owner  <= C_OWN_IF;
                        r_store  <= 1'b0;
                        r_n      <= 3'd4;
                        r_addr   <= if_addr;
                        ram_a    <= if_addr;
                        r_ram_wr <= 1'b0;
                        r_state  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (r_owner == C_OWN_IF && !if_req) begin
                        // Fetch withdrawn: reads have no side effects, just drop it
                        r_owner  <= C_OWN_NONE;
                        r_ram_wr <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else if (r_store) begin
                        if (w_next_cnt == r_n) begin
                            r_ram_wr <= 1'b0;
                            mem_fin  <= 1'b1;
                            r_state  <= ST_DONE;
                        end else begin
                            r_cnt    <= w_next_cnt;
                            ram_a    <= w_next_addr;
                            ram_dout <= w_store_byte;
                        end
                    end else begin
                        r_buf <= w_next_buf;
                        if (r_cnt == r_n) begin
                            if (r_owner == C_OWN_IF) begin
                                if_fin <= 1'b1;
                                if_out <= w_next_buf;
                            end else begin
                                mem_fin <= 1'b1;
                                mem_out <= w_next_buf;
                            end
                            r_state <= ST_DONE;
                        end else begin
                            r_cnt <= w_next_cnt;
                            if (w_next_cnt < r_n) begin
                                ram_a <= w_next_addr;
                            end
                        end
                    end
                end
                default: begin
                    // DONE: single-cycle fin, never accepts so a held request is not replayed
                    if_fin   <= 1'b0;
                    mem_fin  <= 1'b0;
                    r_ram_wr <= 1'b0;
                    r_owner  <= C_OWN_NONE;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl
// Purpose  : Scoreboard bench for mem_ctrl with a byte-array memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, if_req;
    logic [31:0] if_addr, if_out, mem_addr, mem_data, mem_out, ram_a;
    logic        if_fin, mem_fin, ram_wr;
    logic [1:0]  mem_op, mem_len;
    logic [7:0]  ram_din, ram_dout;

    mem_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .if_req(if_req), .if_addr(if_addr), .if_fin(if_fin), .if_out(if_out),
        .mem_op(mem_op), .mem_len(mem_len), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_fin(mem_fin), .mem_out(mem_out),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct { bit is_if; bit is_load; logic [31:0] val; int fcyc; } exp_t;
    typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
    exp_t sb[$];
    wr_t  wq[$];
    logic [7:0] ram     [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction
    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : dflt(a);
    endfunction
    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // RAM read port: synchronous, enabled together with the controller
    initial begin
        ram_din = 8'd0;
        forever begin
            @(posedge clk_in);
            if (rdy_in) ram_din <= ram_rd(ram_a);
        end
    end

    // Write monitor: every accepted RAM write must match the next expected byte
    initial forever begin
        @(negedge clk_in);
        if (!rst_in && ram_wr === 1'b1) begin
            ram[ram_a] = ram_dout;
            if (wq.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_write: got addr %08h data %02h expected no write", ram_a, ram_dout);
            end else begin
                wr_t w;
                w = wq.pop_front();
                chk("wr_addr", ram_a, w.a);
                chk("wr_data", {24'd0, ram_dout}, {24'd0, w.d});
            end
        end
    end

    // Completion monitor: pops the scoreboard on each fin pulse
    initial forever begin
        @(negedge clk_in);
        if (!rst_in && (if_fin === 1'b1 || mem_fin === 1'b1)) begin
            if (if_fin === 1'b1 && mem_fin === 1'b1) chk("both_fin", 32'd1, 32'd0);
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_fin: got if_fin=%0b mem_fin=%0b expected none", if_fin, mem_fin);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("fin_owner_is_if", {31'd0, if_fin}, {31'd0, e.is_if});
                chk("fin_cycle", 32'(cyc), 32'(e.fcyc));
                if (e.is_load) chk("fin_data", if_fin ? if_out : mem_out, e.val);
            end
        end
    end

    // One transaction from accept cycle c0 through the cycle after DONE.
    // mode: 0 no stalls, 1 random rdy stalls, 2 rdy low in c2 and c3.
    task automatic do_txn(input bit is_if, input logic [1:0] op, input logic [1:0] len,
                          input logic [31:0] addr, input logic [31:0] data,
                          input bit keep_if, input logic [31:0] ia, input int mode);
        int n, need, fin_k, act;
        bit st, r;
        bit pat[$];
        exp_t e;
        wr_t w;
        logic [31:0] v;
        st   = !is_if && (op == 2'b10);
        n    = (is_if || len[1]) ? 4 : (len == 2'b00 ? 1 : 2);
        need = st ? n + 1 : n + 2;
        // Active edges needed to reach DONE, plus one to leave it
        act = 0; fin_k = 0;
        for (int k = 0; act <= need; k++) begin
            if (act == need) begin r = 1'b1; fin_k = k; end
            else if (mode == 1) r = ($urandom_range(0, 3) != 0);
            else if (mode == 2) r = !(k == 2 || k == 3);
            else r = 1'b1;
            pat.push_back(r);
            if (r) act++;
        end
        if (is_if) begin
            if_req = 1'b1; if_addr = addr; mem_op = op;
        end else begin
            mem_op = op; mem_len = len; mem_addr = addr; mem_data = data;
            if_req = keep_if; if_addr = ia;
        end
        v = 32'd0;
        for (int i = 0; i < n; i++) begin
            if (st) begin
                w.a = addr + 32'(i); w.d = data[8*i +: 8];
                wq.push_back(w);
                ref_mem[addr + 32'(i)] = data[8*i +: 8];
            end else begin
                v = v | (32'(ref_rd(addr + 32'(i))) << (8 * i));
            end
        end
        e.is_if = is_if; e.is_load = !st; e.val = v; e.fcyc = cyc + fin_k;
        sb.push_back(e);
        act = 0;
        foreach (pat[k]) begin
            rdy_in = pat[k];
            #1;
            if (k >= 1 && act >= 1 && act <= n) begin
                chk("ram_a", ram_a, addr + 32'(act - 1));
                chk("ram_wr", {31'd0, ram_wr}, {31'd0, st & pat[k]});
            end
            if (k >= 1 && act > n) chk("ram_wr_idle", {31'd0, ram_wr}, 32'd0);
            @(posedge clk_in); #1;
            if (pat[k]) act++;
        end
        mem_op = 2'b00; if_req = 1'b0; rdy_in = 1'b1;
        chk("txn_completed", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_if_fin"}, {31'd0, if_fin}, 32'd0);
        chk({tag, "_mem_fin"}, {31'd0, mem_fin}, 32'd0);
        chk({tag, "_if_out"}, if_out, 32'd0);
        chk({tag, "_mem_out"}, mem_out, 32'd0);
        chk({tag, "_ram_dout"}, {24'd0, ram_dout}, 32'd0);
        chk({tag, "_ram_a"}, ram_a, 32'd0);
        chk({tag, "_ram_wr"}, {31'd0, ram_wr}, 32'd0);
    endtask

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        logic [31:0] d, a;
        int kind;
        rst_in = 1'b1; rdy_in = 1'b1; if_req = 1'b0; if_addr = 32'd0;
        mem_op = 2'b00; mem_len = 2'b00; mem_addr = 32'd0; mem_data = 32'd0;
        ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
        ref_mem[32'h100] = 8'h13; ref_mem[32'h101] = 8'h05; ref_mem[32'h102] = 8'h00; ref_mem[32'h103] = 8'h00;
        ram[32'h20] = 8'h80; ref_mem[32'h20] = 8'h80;
        repeat (2) @(posedge clk_in);
        #1;
        chk_all_zero("reset");
        rst_in = 1'b0;

        // Instruction fetch of 0x00000513
        do_txn(1'b1, 2'b00, 2'b10, 32'h100, 32'd0, 1'b0, 32'd0, 0);
        // Simultaneous MEM byte load and fetch: MEM first, fetch right after DONE
        do_txn(1'b0, 2'b01, 2'b00, 32'h20, 32'd0, 1'b1, 32'h100, 0);
        do_txn(1'b1, 2'b00, 2'b10, 32'h100, 32'd0, 1'b0, 32'd0, 0);
        // Half store, upper bytes never written
        do_txn(1'b0, 2'b10, 2'b01, 32'h30, 32'h1234ABCD, 1'b0, 32'd0, 0);
        do_txn(1'b0, 2'b01, 2'b10, 32'h30, 32'd0, 1'b0, 32'd0, 0);
        // Address wrap and rdy stalls in c2/c3
        do_txn(1'b0, 2'b10, 2'b10, 32'hFFFFFFFE, 32'hA1B2C3D4, 1'b0, 32'd0, 0);
        do_txn(1'b0, 2'b01, 2'b11, 32'hFFFFFFFE, 32'd0, 1'b0, 32'd0, 2);
        do_txn(1'b0, 2'b10, 2'b10, 32'h40, 32'h55667788, 1'b0, 32'd0, 2);

        // Fetch withdrawn in c2; a MEM load accepted in c3 proves the controller is idle
        if_req = 1'b1; if_addr = 32'h200; rdy_in = 1'b1;
        @(posedge clk_in); #1;
        chk("abort_ram_wr", {31'd0, ram_wr}, 32'd0);
        @(posedge clk_in); #1;
        if_req = 1'b0;
        @(posedge clk_in); #1;
        do_txn(1'b0, 2'b01, 2'b10, 32'h40, 32'd0, 1'b0, 32'd0, 0);

        // Reset in c2 of a word store: only byte 0 reaches the RAM
        d = 32'hCAFEF00D;
        mem_op = 2'b10; mem_len = 2'b10; mem_addr = 32'h50; mem_data = d;
        begin
            wr_t w;
            w.a = 32'h50; w.d = d[7:0];
            wq.push_back(w);
            ref_mem[32'h50] = d[7:0];
        end
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        rst_in = 1'b1; mem_op = 2'b00;
        #1;
        chk_all_zero("midrst");
        #1;
        rst_in = 1'b0;
        @(posedge clk_in); #1;
        chk("midrst_writes", 32'(wq.size()), 32'd0);
        wq.delete();
        do_txn(1'b0, 2'b01, 2'b10, 32'h50, 32'd0, 1'b0, 32'd0, 0);

        // Randomised traffic with random rdy stalls
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 2);
            a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 15))
                                            : 32'h1000 + 32'($urandom_range(0, 63));
            d = $urandom;
            if (kind == 0) begin
                do_txn(1'b1, ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00, 2'b10, a, 32'd0,
                       1'b0, 32'd0, 1);
            end else if ($urandom_range(0, 3) == 0) begin
                do_txn(1'b0, (kind == 1) ? 2'b01 : 2'b10, 2'($urandom_range(0, 3)), a, d,
                       1'b1, 32'h1020, 1);
                do_txn(1'b1, 2'b00, 2'b10, 32'h1020, 32'd0, 1'b0, 32'd0, 1);
            end else begin
                do_txn(1'b0, (kind == 1) ? 2'b01 : 2'b10, 2'($urandom_range(0, 3)), a, d,
                       1'b0, 32'd0, 1);
            end
        end

        repeat (4) @(posedge clk_in);
        #1;
        chk("final_writes", 32'(wq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller that serialises all CPU memory traffic onto the single byte-wide RAM port. It arbitrates between the instruction-fetch stage (word reads only) and the MEM stage (byte/half/word loads and stores). It splits each request into sequential byte accesses, assembles little-endian read data, and returns it with a one-cycle `fin` pulse. Sits between the pipeline stages and the RAM; the MEM stage holds its request until `mem_fin`.

## Interface
- No parameters. Encodings are fixed:
  - op: 2'b00 NONE, 2'b01 LOAD, 2'b10 SAVE, 2'b11 treated as NONE.
  - len: 2'b00 BYTE, 2'b01 HALF, 2'b10 WORD, 2'b11 treated as WORD.
- Reset: one clock; reset is asynchronous and active-high. Ports `clk_in` and `rst_in`.

Ports:
- `clk_in` in 1: clock.
- `rst_in` in 1: async reset, active-high.
- `rdy_in` in 1: global enable; 0 freezes all state.
- `if_req` in 1: fetch request.
- `if_addr` in 32: fetch byte address.
- `if_fin` out 1: one-cycle fetch-done pulse.
- `if_out` out 32: fetched word, valid while `if_fin`=1.
- `mem_op` in 2: MEM-stage op (NONE/LOAD/SAVE).
- `mem_len` in 2: access length.
- `mem_addr` in 32: byte address.
- `mem_data` in 32: store data; low `len` bytes used.
- `mem_fin` out 1: one-cycle done pulse.
- `mem_out` out 32: zero-extended load data, valid while `mem_fin`=1.
- `ram_din` in 8: RAM read data.
- `ram_dout` out 8: RAM write data.
- `ram_a` out 32: RAM byte address.
- `ram_wr` out 1: 1 = write, 0 = read.

## Operation
- FSM states: IDLE, BUSY, DONE. All outputs are registered except `ram_wr` gating (see rdy).
- Reset values:
  - state IDLE, byte counter 0, owner NONE.
  - All outputs 0: `if_fin`, `mem_fin`, `if_out`, `mem_out`, `ram_dout`, `ram_a`, `ram_wr`.
- IDLE:
  - `mem_op`≠NONE → accept MEM.
  - else `if_req`=1 → accept IF as a WORD load.
  - Otherwise stay in IDLE.
  - Fixed priority: MEM wins simultaneous requests. IF waits, no starvation counter.
- Accept: latch op, len (N = 1/2/4 bytes), addr, store data, and owner; go to BUSY.
- BUSY, load:
  - Issue `ram_a` = addr+i for i = 0..N-1 on consecutive cycles, `ram_wr`=0.
  - Byte i is sampled from `ram_din` one cycle after its address and placed at bits [8i+7:8i].
  - Unused upper bytes are 0.
  - After the last byte is sampled → DONE.
- BUSY, store:
  - Drive `ram_a` = addr+i, `ram_dout` = data[8i+7:8i], `ram_wr`=1 for i = 0..N-1.
  - After the last byte → DONE.
- Address arithmetic is 32-bit modulo 2^32; 0xFFFFFFFF+1 wraps to 0. Misaligned addresses are allowed.
- DONE:
  - Pulse the owner's `fin` for one cycle with its `out` valid.
  - `ram_wr`=0; next state IDLE.
  - No request is accepted in DONE. This guarantees a request still visible on the `fin` cycle is not re-issued.
- `out` holds its value after `fin` drops.
- IF abort: if `if_req`=0 at any edge while owner=IF in BUSY → return to IDLE with no `if_fin` (reads have no side effects).
- MEM transactions are never aborted; inputs are ignored after accept.
- `rdy_in`=0:
  - No state, counter, or output register changes.
  - `ram_wr` is forced 0 combinationally, so a pending store byte is issued once `rdy_in` returns.
- Reset mid-transaction: immediate return to reset values, no `fin`. Store bytes already written remain in RAM.

## Timing
- Accept cycle = c0 (IDLE, request present).
- Load of N bytes:
  - Addresses driven c1..cN.
  - Data returns c2..c(N+1).
  - `fin` in c(N+2).
  - Word load: `fin` at c6; byte load: `fin` at c3.
- Store of N bytes:
  - Writes driven c1..cN.
  - `fin` in c(N+1).
  - Word store: `fin` at c5.
- Earliest next accept is the cycle after DONE (c(N+3) for loads, c(N+2) for stores).
- Each `rdy_in`=0 cycle adds exactly one cycle of latency.

## Test plan
- IF word fetch at 0x00000100, RAM bytes 13 05 00 00:
  - `ram_a` = 0x100..0x103 in c1..c4, `ram_wr`=0 throughout.
  - `if_fin`=1 only in c6 with `if_out`=0x00000513.
- Simultaneous MEM LOAD BYTE at 0x20 (RAM 0x80) and `if_req`:
  - MEM served first; `mem_fin` at c3 with `mem_out`=0x00000080.
  - IF accepted in the cycle after DONE.
- MEM SAVE HALF 0x1234ABCD at 0x30:
  - c1: `ram_wr`=1, `ram_a`=0x30, `ram_dout`=0xCD.
  - c2: `ram_wr`=1, `ram_a`=0x31, `ram_dout`=0xAB.
  - `mem_fin` at c3; 0x12/0x34 never written.
- Boundary and hold cases:
  - SAVE WORD at 0xFFFFFFFE → addresses FFFFFFFE, FFFFFFFF, 00000000, 00000001.
  - `rdy_in`=0 for 2 cycles during c2 → `fin` delayed by exactly 2 cycles; each byte written exactly once.
- IF abort and reset:
  - Drop `if_req` in c2 of a fetch → state IDLE next cycle, `if_fin` never pulses.
  - `rst_in` pulse mid-store → all outputs 0 asynchronously, no `fin`.
- Held request after `fin`:
  - MEM LOAD request held through the `fin` cycle → exactly one transaction, no re-accept in DONE.
